// File: rtl/acq_frontend.sv
// acq_frontend: one-channel acquisition front end. Selects a channel from a
// packed multi-channel sample bus, converts it to signed, decimates, block
// averages over 2^k samples and presents the result on a valid/ready output.
//
// Output handshake: out_data is meaningful whenever out_valid is high, and
// both hold until the cycle where out_valid & out_ready are both high. A new
// result that arrives while an unaccepted one is pending is dropped and
// raises the sticky overrun flag.
module acq_frontend #(
    parameter int N_CH    = 2,
    parameter int IN_W    = 14,
    parameter int OUT_W   = 32,
    parameter int MAX_AVG = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [N_CH*IN_W-1:0]   din,
    input  logic                   din_valid,
    input  logic [2:0]             sel_ch,
    input  logic                   offset_bin,
    input  logic                   sync_mode,
    input  logic                   trigger,
    input  logic [15:0]            decim,
    input  logic [3:0]             avg_log2,
    input  logic [31:0]            n_out,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overrun,
    output logic                   done,
    output logic                   busy,
    output logic [1:0]             o_dbg_state
);

    // Accumulator holds 2^MAX_AVG full-scale samples without overflow.
    localparam int         ACC_W     = IN_W + MAX_AVG;
    // Kept-sample counter must reach 2^MAX_AVG.
    localparam int         CNT_W     = MAX_AVG + 1;
    localparam logic [3:0] MAX_AVG_L = 4'(MAX_AVG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Control state
    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;

    // Configuration captured when leaving IDLE
    logic [2:0]              r_sel_ch;
    logic                    r_offset_bin;
    logic [15:0]             r_decim;
    logic [3:0]              r_avg_log2;
    logic [31:0]             r_n_out;

    // Datapath state
    logic [15:0]             r_dec_cnt;
    logic [CNT_W-1:0]        r_avg_cnt;
    logic signed [ACC_W-1:0] r_acc;
    logic [31:0]             r_out_cnt;

    // Output register
    logic [OUT_W-1:0]        r_out_data;
    logic                    r_out_valid;
    logic                    r_overrun;

    // Combinational helpers
    logic                    w_start;
    logic                    w_abort;
    logic                    w_run_cycle;
    logic                    w_take;
    logic                    w_keep;
    logic                    w_dec_wrap;
    logic [3:0]              w_avg_clamp;
    logic [IN_W-1:0]         w_raw;
    logic [IN_W-1:0]         w_conv;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shifted;
    logic [CNT_W-1:0]        w_avg_len;
    logic                    w_avg_full;
    logic                    w_prod;
    logic                    w_last_out;
    logic signed [OUT_W-1:0] w_result;

    // Leaving IDLE latches config; dropping enable anywhere else aborts.
    assign w_start     = (r_state == S_IDLE) && enable;
    assign w_abort     = (r_state != S_IDLE) && !enable;

    // A cycle that may consume din: RUN, or the ARMED cycle carrying the
    // trigger (its sample is the first one considered).
    assign w_run_cycle = enable && ((r_state == S_RUN) ||
                                    ((r_state == S_ARMED) && trigger));
    assign w_take      = w_run_cycle && din_valid;

    // Decimation: keep the sample when the modulo counter sits at zero.
    assign w_dec_wrap  = (r_decim <= 16'd1) || (r_dec_cnt == (r_decim - 16'd1));
    assign w_keep      = w_take && (r_dec_cnt == 16'd0);

    assign w_avg_clamp = (avg_log2 > MAX_AVG_L) ? MAX_AVG_L : avg_log2;

    // Pick the selected channel; out-of-range selects fall back to channel 0.
    always_comb begin
        w_raw = din[IN_W-1:0];
        for (int k = 0; k < N_CH; k++) begin
            if (r_sel_ch == 3'(k)) begin
                w_raw = din[k*IN_W +: IN_W];
            end
        end
    end

    // Offset binary becomes two's complement by flipping the MSB.
    assign w_conv     = {w_raw[IN_W-1] ^ r_offset_bin, w_raw[IN_W-2:0]};
    assign w_ext      = {{MAX_AVG{w_conv[IN_W-1]}}, w_conv};

    assign w_sum      = r_acc + w_ext;
    assign w_avg_len  = CNT_W'(1) << r_avg_log2;
    assign w_avg_full = ((r_avg_cnt + CNT_W'(1)) == w_avg_len);
    assign w_prod     = w_keep && w_avg_full;

    // Arithmetic shift floors toward minus infinity.
    assign w_shifted  = w_sum >>> r_avg_log2;
    assign w_result   = OUT_W'(w_shifted);

    // The result being produced now is the final one of a finite run.
    assign w_last_out = (r_n_out != 32'd0) && ((r_out_cnt + 32'd1) == r_n_out);

    // Control FSM: state, busy, done pulse and config capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sel_ch     <= 3'd0;
            r_offset_bin <= 1'b0;
            r_decim      <= 16'd0;
            r_avg_log2   <= 4'd0;
            r_n_out      <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_sel_ch     <= sel_ch;
                        r_offset_bin <= offset_bin;
                        r_decim      <= decim;
                        r_avg_log2   <= w_avg_clamp;
                        r_n_out      <= n_out;
                        r_busy       <= 1'b1;
                        r_state      <= sync_mode ? S_ARMED : S_RUN;
                    end
                end
                S_ARMED, S_RUN: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_run_cycle) begin
                        if (w_prod && w_last_out) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    if (!enable) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Decimation counter, accumulator and produced-result counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dec_cnt <= 16'd0;
            r_avg_cnt <= '0;
            r_acc     <= '0;
            r_out_cnt <= 32'd0;
        end else if (w_abort) begin
            // Leaving for IDLE discards any partial average.
            r_dec_cnt <= 16'd0;
            r_avg_cnt <= '0;
            r_acc     <= '0;
            r_out_cnt <= 32'd0;
        end else begin
            if (w_take) begin
                r_dec_cnt <= w_dec_wrap ? 16'd0 : (r_dec_cnt + 16'd1);
            end
            if (w_keep) begin
                if (w_avg_full) begin
                    // Block complete: next kept sample starts a fresh sum.
                    r_acc     <= '0;
                    r_avg_cnt <= '0;
                end else begin
                    r_acc     <= w_sum;
                    r_avg_cnt <= r_avg_cnt + CNT_W'(1);
                end
            end
            if (w_prod) begin
                r_out_cnt <= r_out_cnt + 32'd1;
            end
        end
    end

    // Output register with hold-until-accepted and sticky overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_prod) begin
                if (!r_out_valid || out_ready) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_result;
                end else begin
                    r_overrun   <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            // A new acquisition starts with a clean overrun flag.
            if (w_start) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign overrun     = r_overrun;
    assign done        = r_done;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_acq_frontend.sv
// tb_acq_frontend: directed scenarios against a queue-based reference model
// of the acquisition front end, plus literal expectations at key points.
module tb_acq_frontend;

    localparam int N_CH    = 2;
    localparam int IN_W    = 14;
    localparam int OUT_W   = 32;
    localparam int MAX_AVG = 8;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic                 enable     = 1'b0;
    logic [N_CH*IN_W-1:0] din        = '0;
    logic                 din_valid  = 1'b0;
    logic [2:0]           sel_ch     = 3'd0;
    logic                 offset_bin = 1'b0;
    logic                 sync_mode  = 1'b0;
    logic                 trigger    = 1'b0;
    logic [15:0]          decim      = 16'd0;
    logic [3:0]           avg_log2   = 4'd0;
    logic [31:0]          n_out      = 32'd0;
    logic                 out_ready  = 1'b0;
    logic [OUT_W-1:0]     out_data;
    logic                 out_valid;
    logic                 overrun;
    logic                 done;
    logic                 busy;
    logic [1:0]           dbg_state;

    acq_frontend #(
        .N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W), .MAX_AVG(MAX_AVG)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .din(din), .din_valid(din_valid), .sel_ch(sel_ch),
        .offset_bin(offset_bin), .sync_mode(sync_mode), .trigger(trigger),
        .decim(decim), .avg_log2(avg_log2), .n_out(n_out),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overrun(overrun), .done(done), .busy(busy), .o_dbg_state(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Mode: 0 idle, 1 armed (waiting for trigger), 2 running, 3 finished.
    int          m_mode = 0;
    int          m_ch, m_off, m_dec, m_avg;
    longint      m_nout, m_produced;
    int          m_vcount;
    int          m_kept[$];
    logic        m_ov = 1'b0;
    logic [31:0] m_od = '0;
    logic        m_overrun = 1'b0;
    logic        m_done = 1'b0;

    function automatic int sample_of(input logic [N_CH*IN_W-1:0] d, input int ch, input int off);
        int raw;
        raw = int'((d >> (ch*IN_W)) & ((1 << IN_W) - 1));
        if (off != 0) return raw - (1 << (IN_W-1));
        if (raw >= (1 << (IN_W-1))) return raw - (1 << IN_W);
        return raw;
    endfunction

    task automatic model_step();
        bit     consider;
        bit     prod;
        int     res;
        longint s;
        if (!reset_n) begin
            m_mode = 0; m_ch = 0; m_off = 0; m_dec = 1; m_avg = 0;
            m_nout = 0; m_produced = 0; m_vcount = 0; m_kept.delete();
            m_ov = 1'b0; m_od = '0; m_overrun = 1'b0; m_done = 1'b0;
            return;
        end
        consider = 0; prod = 0; res = 0; m_done = 1'b0;
        case (m_mode)
            0: if (enable) begin
                m_ch       = (int'(sel_ch) < N_CH) ? int'(sel_ch) : 0;
                m_off      = int'(offset_bin);
                m_dec      = (decim == 16'd0) ? 1 : int'(decim);
                m_avg      = (int'(avg_log2) > MAX_AVG) ? MAX_AVG : int'(avg_log2);
                m_nout     = longint'(n_out);
                m_overrun  = 1'b0;
                m_vcount   = 0;
                m_produced = 0;
                m_kept.delete();
                m_mode     = sync_mode ? 1 : 2;
            end
            1: if (!enable) m_mode = 0;
               else if (trigger) begin m_mode = 2; consider = 1; end
            2: if (!enable) m_mode = 0; else consider = 1;
            default: if (!enable) m_mode = 0;
        endcase
        if (m_mode == 0) begin
            m_vcount = 0; m_kept.delete(); m_produced = 0;
        end
        if (consider && din_valid) begin
            if (m_vcount % m_dec == 0) m_kept.push_back(sample_of(din, m_ch, m_off));
            m_vcount++;
            if (m_kept.size() == (1 << m_avg)) begin
                s = 0;
                foreach (m_kept[i]) s += m_kept[i];
                res = int'(s >>> m_avg);
                prod = 1;
                m_kept.delete();
                m_produced++;
                if (m_nout != 0 && m_produced == m_nout) begin
                    m_mode = 3;
                    m_done = 1'b1;
                end
            end
        end
        if (prod) begin
            if (!m_ov || out_ready) begin m_ov = 1'b1; m_od = res; end
            else m_overrun = 1'b1;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk);
        check("m_out_valid", out_valid, m_ov);
        if (m_ov) check("m_out_data", out_data, m_od);
        check("m_overrun", overrun, m_overrun);
        check("m_done", done, m_done);
        check("m_busy", busy, (m_mode == 1 || m_mode == 2));
        check("m_state", dbg_state, m_mode);
    end

    // ---------------- driver tasks ----------------
    task automatic set_ch(input int ch, input int val);
        logic [IN_W-1:0] v;
        v = val[IN_W-1:0];
        din[ch*IN_W +: IN_W] = v;
    endtask

    task automatic set_cfg(input bit sm, input logic [2:0] ch, input bit ob,
                           input logic [15:0] dc, input logic [3:0] al, input logic [31:0] no);
        sync_mode = sm; sel_ch = ch; offset_bin = ob; decim = dc; avg_log2 = al; n_out = no;
    endtask

    task automatic stop_run();
        din_valid = 1'b0; trigger = 1'b0; enable = 1'b0;
        @(negedge clk);
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    // ---------------- directed stimulus ----------------
    int s2[10];
    int nv;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Offset binary mid-scale on channel 1 converts to zero every cycle
        set_cfg(0, 3'd1, 1, 16'd1, 4'd0, 32'd0);
        out_ready = 1'b1;
        set_ch(1, 'h2000);
        set_ch(0, rnd_sample());
        din_valid = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        check("s1_latency_valid", out_valid, 0);
        check("s1_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            set_ch(0, rnd_sample());
            if (i == 2) offset_bin = 1'b0;   // must be ignored mid-run
            @(negedge clk);
            check("s1_valid", out_valid, 1);
            check("s1_data", out_data, 0);
        end
        stop_run();
        check("s1_valid_after", out_valid, 0);
        check("s1_state_idle", dbg_state, 0);

        // Decimate by 3, average 4: kept 4,8,-4,12 -> 20/4 = 5
        set_cfg(0, 3'd0, 0, 16'd3, 4'd2, 32'd0);
        s2 = '{4, 0, 0, 8, 0, 0, -4, 0, 0, 12};
        foreach (s2[i]) if (i % 3 != 0) s2[i] = rnd_sample();
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            set_ch(0, s2[i]);
            set_ch(1, rnd_sample());
            din_valid = 1'b1;
            @(negedge clk);
            if (i < 9) check("s2_no_valid", out_valid, 0);
        end
        check("s2_valid", out_valid, 1);
        check("s2_data", out_data, 5);
        stop_run();
        check("s2_single", out_valid, 0);

        // Sync mode: wait for trigger, trigger-cycle sample is first
        set_cfg(1, 3'd0, 0, 16'd1, 4'd0, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("s3_armed", dbg_state, 1);
        for (int i = 0; i < 4; i++) begin
            set_ch(0, 500 + i);
            din_valid = 1'b1;
            @(negedge clk);
            check("s3_no_out", out_valid, 0);
            check("s3_busy", busy, 1);
        end
        set_ch(0, 77);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("s3_trig_valid", out_valid, 1);
        check("s3_trig_data", out_data, 77);
        check("s3_run", dbg_state, 2);
        set_ch(0, -78);
        @(negedge clk);
        check("s3_neg_data", out_data, -78);
        stop_run();

        // n_out = 3: exactly three results, done with the third
        set_cfg(0, 3'd0, 0, 16'd1, 4'd0, 32'd3);
        set_ch(0, 0);
        din_valid = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            set_ch(0, i + 1);
            @(negedge clk);
            if (out_valid) begin
                nv++;
                check("s4_data", out_data, nv);
                check("s4_done", done, (nv == 3));
            end
        end
        check("s4_count", nv, 3);
        check("s4_state_done", dbg_state, 3);
        check("s4_busy", busy, 0);
        stop_run();

        // Back-pressure: first result held, later ones dropped
        set_cfg(0, 3'd0, 0, 16'd1, 4'd0, 32'd0);
        out_ready = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            set_ch(0, 10 * (i + 1));
            din_valid = 1'b1;
            @(negedge clk);
            check("s5_overrun_step", overrun, (i != 0));
        end
        check("s5_held_data", out_data, 10);
        check("s5_held_valid", out_valid, 1);
        stop_run();
        check("s5_idle_valid", out_valid, 1);
        check("s5_idle_overrun", overrun, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("s5_accepted", out_valid, 0);
        enable = 1'b1;
        @(negedge clk);
        check("s5_overrun_clr", overrun, 0);
        stop_run();

        // Asynchronous reset in the middle of a 4-sample average
        set_cfg(0, 3'd0, 0, 16'd1, 4'd2, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            set_ch(0, 100);
            din_valid = 1'b1;
            @(negedge clk);
        end
        din_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("s6_rst_data", out_data, 0);
        check("s6_rst_valid", out_valid, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_state", dbg_state, 0);
        check("s6_rst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("s6_first_edge_run", dbg_state, 2);
        s2 = '{1, 2, 3, 6, -1, -2, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            set_ch(0, s2[i]);
            din_valid = 1'b1;
            @(negedge clk);
            if (i == 3) check("s6_fresh_avg", out_data, 3);
            if (i == 7) check("s6_floor_avg", out_data, -1);
        end
        stop_run();

        // Channel select out of range, offset binary full scale, avg clamp
        set_cfg(0, 3'd7, 1, 16'd0, 4'd12, 32'd0);
        set_ch(0, 'h3FFF);
        set_ch(1, 0);
        enable = 1'b1;
        @(negedge clk);
        din_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i < 255) check("s7_no_valid", out_valid, 0);
        end
        check("s7_valid", out_valid, 1);
        check("s7_full_scale", out_data, 8191);
        stop_run();

        // Mixed traffic checked by the model alone
        set_cfg(1, 3'd1, 0, 16'd2, 4'd1, 32'd5);
        enable = 1'b1;
        for (int i = 0; i < 120; i++) begin
            set_ch(0, rnd_sample());
            set_ch(1, rnd_sample());
            din_valid = 1'($urandom_range(0, 3) != 0);
            trigger   = 1'($urandom_range(0, 7) == 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        stop_run();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/acq_frontend.md
ACQ_FRONTEND -- requirements
Module: acq_frontend

Interface
REQ-001 Parameter N_CH, default 2: number of input channels, 1..8.
REQ-002 Parameter IN_W, default 14: input sample width.
REQ-003 Parameter OUT_W, default 32: output sample width; SHALL be at least IN_W+MAX_AVG.
REQ-004 Parameter MAX_AVG, default 8: maximum log2 of the averaging length.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; one clock; all logic rising-edge.
- reset_n  in  1  reset; asynchronous, active-low.
- enable  in  1  run request; level.
- din  in  N_CH*IN_W  packed samples; channel k at bits [k*IN_W +: IN_W].
- din_valid  in  1  din qualifier; one sample per channel per high cycle.
- sel_ch  in  3  channel select; values >= N_CH select channel 0.
- offset_bin  in  1  1: din is offset binary; 0: din is two's complement.
- sync_mode  in  1  1: wait for trigger before acquiring.
- trigger  in  1  start pulse, e.g. DAC period start.
- decim  in  16  keep 1 of every decim valid samples; 0 and 1 both mean keep all.
- avg_log2  in  4  average 2^avg_log2 kept samples; values above MAX_AVG clamp to MAX_AVG.
- n_out  in  32  outputs to produce; 0 = continuous.
- out_data  out  OUT_W  averaged sample, two's complement.
- out_valid  out  1  out_data qualifier.
- out_ready  in  1  downstream accept.
- overrun  out  1  sticky flag: a result was dropped.
- done  out  1  one-cycle pulse when n_out results have been produced.
- busy  out  1  high in ARMED or RUN.

Function
REQ-006 The block SHALL implement states IDLE, ARMED, RUN and DONE.
REQ-007 From IDLE with enable=1, the next state SHALL be ARMED if sync_mode=1, else RUN. On this transition the block SHALL latch sel_ch, offset_bin, decim, avg_log2 and n_out, and SHALL clear overrun.
REQ-008 From ARMED with trigger=1, the next state SHALL be RUN. The din_valid sample in the trigger cycle SHALL be the first sample considered.
REQ-009 From RUN, when the n_out-th result is produced (n_out != 0), the next state SHALL be DONE, and done SHALL pulse in the same cycle that out_valid rises.
REQ-010 With enable=0 in ARMED, RUN or DONE, the next state SHALL be IDLE. The accumulator and counters SHALL clear, and any partial average SHALL be discarded.
REQ-011 A pending out_valid SHALL be unaffected by the transition to IDLE.
REQ-012 Config inputs SHALL be ignored outside the IDLE exit cycle.
REQ-013 Sample conversion: if offset_bin=1, the MSB of the selected sample SHALL be inverted. The result SHALL be sign-extended to ACC_W = IN_W+MAX_AVG.
REQ-014 Decimation: a modulo-decim counter SHALL advance on each din_valid in RUN. A sample SHALL be kept when the counter is 0, so the first sample in RUN is kept.
REQ-015 Averaging: kept samples SHALL be summed in an ACC_W signed accumulator. After 2^avg_log2 kept samples, the result SHALL be sum >>> avg_log2 (arithmetic shift, truncating toward minus infinity), sign-extended to OUT_W.
REQ-016 The accumulator SHALL restart from the next kept sample, with no gap.
REQ-017 Latency: out_valid SHALL rise on the clock edge after the din_valid cycle of the last contributing sample.
REQ-018 Output handshake: out_data and out_valid SHALL hold until out_valid & out_ready. out_valid SHALL fall on the next edge unless a new result is produced in that same cycle, in which case out_valid stays high with the new data.
REQ-019 If a result is produced while out_valid=1 and out_ready=0, the new result SHALL be dropped, overrun SHALL set, and the result SHALL still count toward n_out.
REQ-020 din_valid outside RUN SHALL be ignored.
REQ-021 In continuous mode (n_out=0), the output counter SHALL not terminate RUN and SHALL not pulse done.
REQ-022 The accumulator SHALL be sized so that 2^MAX_AVG full-scale samples cannot overflow.

Reset
REQ-023 On reset_n=0, asynchronously: state SHALL be IDLE; out_data SHALL be 0; out_valid, overrun, done and busy SHALL be 0; all counters and the accumulator SHALL be 0; latched config SHALL be 0.
REQ-024 Reset asserted mid-RUN SHALL discard all partial and pending results, with no done pulse.
REQ-025 After reset_n rises with enable=1 held, IDLE SHALL exit on the first clock edge.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- sync_mode=0, decim=1, avg_log2=0, offset_bin=1, sel_ch=1, din ch1=14'h2000 valid every cycle, out_ready=1 -> out_data=0 each cycle, 1-cycle latency.
- avg_log2=2, decim=3, two's complement samples 4,x,x,8,x,x,-4,x,x,12 on valid -> a single out_data=5 one cycle after the sample 12.
- sync_mode=1, valids before trigger -> no output, busy=1; trigger pulse -> the first output uses the trigger-cycle sample.
- n_out=3, avg_log2=0 -> exactly 3 out_valid; done pulses with the third; state DONE; busy=0.
- out_ready=0 while results arrive -> first result held, later results dropped, overrun=1; enable low then high -> overrun=0.
- reset_n low mid-average (2 of 4 samples) -> all outputs 0 asynchronously; after release, a fresh average of 4 samples excludes the old partial samples.
